// File: rtl/jpeg_block_to_raster_if.sv
// Pixel streams around jpeg_block_to_raster: block-ordered RGB from the decoder
// and the raster-ordered {R,G,B} output with frame/line markers.
interface jpeg_block_to_raster_if;
  logic [7:0]  in_r;
  logic [7:0]  in_g;
  logic [7:0]  in_b;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eol;
  logic        out_eof;

  modport master (
    output in_r, in_g, in_b, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sof, out_eol, out_eof
  );

  modport slave (
    input  in_r, in_g, in_b, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sof, out_eol, out_eof
  );
endinterface

// File: rtl/jpeg_block_to_raster.sv
// Reorders 8x8-block pixel order into raster order through a ping-pong pair of
// one-strip (8 lines) buffers; write and read sides run concurrently.
module jpeg_block_to_raster #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic                   clk,
  input  logic                   rst,
  jpeg_block_to_raster_if.slave  bus,
  output logic                   overflow
);
  localparam int DEPTH = 8 * IMG_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int NBX   = IMG_W / 8;
  localparam int NST   = IMG_H / 8;
  localparam int BXW   = (NBX > 1) ? $clog2(NBX) : 1;
  localparam int SW    = (NST > 1) ? $clog2(NST) : 1;
  localparam int CW    = $clog2(IMG_W);

  logic [23:0]    mem [2][DEPTH];
  logic [1:0]     full;
  logic           wr_bank;
  logic           rd_bank;
  logic [2:0]     col;
  logic [2:0]     row;
  logic [BXW-1:0] bx;
  logic [AW-1:0]  waddr;
  logic [AW-1:0]  raddr;
  logic [CW-1:0]  rcol;
  logic [SW-1:0]  strip;
  logic           in_acc;
  logic           out_acc;
  logic           strip_done;
  logic           bank_release;

  // Write side
  assign bus.in_ready = !full[wr_bank];
  assign in_acc       = bus.in_valid && bus.in_ready;
  assign strip_done   = in_acc && (col == 3'd7) && (row == 3'd7) && (bx == BXW'(NBX - 1));
  assign waddr        = AW'(row) * AW'(IMG_W) + AW'(bx) * AW'(8) + AW'(col);

  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      bx      <= '0;
      wr_bank <= 1'b0;
    end else if (in_acc) begin
      col <= col + 3'd1;
      if (col == 3'd7) begin
        row <= row + 3'd1;
        if (row == 3'd7)
          bx <= (bx == BXW'(NBX - 1)) ? '0 : bx + BXW'(1);
      end
      if (strip_done)
        wr_bank <= !wr_bank;
    end
  end

  // NOTE: the pixel store carries no reset; every word is written before the
  // read side can reach it, so clearing it would only cost logic.
  always_ff @(posedge clk) begin
    if (in_acc)
      mem[wr_bank][waddr] <= {bus.in_r, bus.in_g, bus.in_b};
  end

  // Read side
  assign bus.out_valid = full[rd_bank];
  assign bus.out_data  = mem[rd_bank][raddr];
  assign out_acc       = bus.out_valid && bus.out_ready;
  assign bank_release  = out_acc && (raddr == AW'(DEPTH - 1));
  assign bus.out_sof   = bus.out_valid && (strip == '0) && (raddr == '0);
  assign bus.out_eol   = bus.out_valid && (rcol == CW'(IMG_W - 1));
  assign bus.out_eof   = bus.out_valid && (strip == SW'(NST - 1)) && (raddr == AW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      raddr   <= '0;
      rcol    <= '0;
      strip   <= '0;
      rd_bank <= 1'b0;
    end else if (out_acc) begin
      rcol <= (rcol == CW'(IMG_W - 1)) ? '0 : rcol + CW'(1);
      if (bank_release) begin
        raddr   <= '0;
        rd_bank <= !rd_bank;
        strip   <= (strip == SW'(NST - 1)) ? '0 : strip + SW'(1);
      end else begin
        raddr <= raddr + AW'(1);
      end
    end
  end

  // NOTE: set and release in one cycle always hit different banks, so both
  // bit updates land; neither overrides the other.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 2'b00;
    end else begin
      if (strip_done)
        full[wr_bank] <= 1'b1;
      if (bank_release)
        full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      overflow <= 1'b0;
    else if (bus.in_valid && !bus.in_ready)
      overflow <= 1'b1;
  end
endmodule

// File: tb/tb_jpeg_block_to_raster.sv
// Directed/random bench for jpeg_block_to_raster: a strip-level reference model
// predicts every handshake, pixel and marker; 16x16 and 160x120 instances.
module tb_jpeg_block_to_raster;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jpeg_block_to_raster_if ba ();
  jpeg_block_to_raster_if bb ();
  logic ovf_a;
  logic ovf_b;

  jpeg_block_to_raster #(.IMG_W(16), .IMG_H(16)) dut_a (
    .clk(clk), .rst(rst), .bus(ba), .overflow(ovf_a)
  );
  jpeg_block_to_raster dut_b (
    .clk(clk), .rst(rst), .bus(bb), .overflow(ovf_b)
  );

  // Shared stimulus, steered to the instance under test by sel
  logic        sel;
  logic [23:0] px;
  logic        in_valid;
  logic        out_ready;

  assign ba.in_r = px[23:16];
  assign ba.in_g = px[15:8];
  assign ba.in_b = px[7:0];
  assign bb.in_r = px[23:16];
  assign bb.in_g = px[15:8];
  assign bb.in_b = px[7:0];
  assign ba.in_valid  = in_valid && !sel;
  assign bb.in_valid  = in_valid && sel;
  assign ba.out_ready = out_ready && !sel;
  assign bb.out_ready = out_ready && sel;

  logic        o_in_ready, o_valid, o_sof, o_eol, o_eof, o_ovf, o_rd_full, o_banks_differ;
  logic [23:0] o_data;
  always_comb begin
    o_in_ready     = sel ? bb.in_ready  : ba.in_ready;
    o_valid        = sel ? bb.out_valid : ba.out_valid;
    o_data         = sel ? bb.out_data  : ba.out_data;
    o_sof          = sel ? bb.out_sof   : ba.out_sof;
    o_eol          = sel ? bb.out_eol   : ba.out_eol;
    o_eof          = sel ? bb.out_eof   : ba.out_eof;
    o_ovf          = sel ? ovf_b        : ovf_a;
    o_rd_full      = sel ? dut_b.full[dut_b.rd_bank] : dut_a.full[dut_a.rd_bank];
    o_banks_differ = sel ? (dut_b.wr_bank != dut_b.rd_bank) : (dut_a.wr_bank != dut_a.rd_bank);
  end

  int checks = 0;
  int errors = 0;

  // Reference model: strips buffered, block-order fill of a raster strip image
  int          mw, mh;
  int          m_cnt;
  int          m_k;
  int          m_in_strip;
  int          m_out_n;
  int          m_acc_total;
  bit          m_ovf;
  logic [23:0] sbuf [8*160];
  logic [23:0] expq [$];

  // Observed output statistics
  int n_out, n_eol, n_eof, n_sof, eof_idx, last_sof_idx;

  int  vmode;  // 0 idle, 1 continuous, 2 random
  int  rmode;  // 0 stalled, 1 always ready, 2 random
  bit  coord;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_k = 0; m_in_strip = 0; m_out_n = 0; m_ovf = 1'b0;
    expq.delete();
  endtask

  task automatic clear_stats();
    n_out = 0; n_eol = 0; n_eof = 0; n_sof = 0; eof_idx = -1; last_sof_idx = -1;
  endtask

  function automatic logic [23:0] coord_px();
    int blk = m_k / 64;
    int w   = m_k % 64;
    int x   = blk * 8 + w % 8;
    int y   = m_in_strip * 8 + w / 8;
    return {8'(x), 8'(y), 8'h5A};
  endfunction

  task automatic tick();
    bit m_ir, m_ov, acc_in, acc_out;
    int idx;
    @(negedge clk);
    m_ir = (m_cnt < 2);
    m_ov = (m_cnt > 0);
    check("in_ready", 32'(o_in_ready), 32'(m_ir));
    check("out_valid", 32'(o_valid), 32'(m_ov));
    check("overflow", 32'(o_ovf), 32'(m_ovf));
    if (m_ov) begin
      check("out_data", 32'(o_data), 32'(expq[0]));
      check("out_sof", 32'(o_sof), 32'(m_out_n == 0));
      check("out_eol", 32'(o_eol), 32'(m_out_n % mw == mw - 1));
      check("out_eof", 32'(o_eof), 32'(m_out_n == mw * mh - 1));
    end
    if (in_valid && o_in_ready && o_rd_full)
      check("bank_sep", 32'(o_banks_differ), 32'd1);
    if (o_valid && out_ready) begin
      if (o_sof) begin n_sof++; last_sof_idx = n_out; end
      if (o_eol) n_eol++;
      if (o_eof) begin n_eof++; eof_idx = n_out; end
      n_out++;
    end
    acc_in  = in_valid && m_ir;
    acc_out = m_ov && out_ready;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (in_valid && !m_ir) m_ovf = 1'b1;
      if (acc_out) begin
        void'(expq.pop_front());
        m_out_n = (m_out_n + 1) % (mw * mh);
        if (m_out_n % (8 * mw) == 0) m_cnt--;
      end
      if (acc_in) begin
        idx = ((m_k % 64) / 8) * mw + (m_k / 64) * 8 + (m_k % 8);
        sbuf[idx] = px;
        m_k++;
        m_acc_total++;
        if (m_k == 8 * mw) begin
          for (int i = 0; i < 8 * mw; i++) expq.push_back(sbuf[i]);
          m_k = 0;
          m_cnt++;
          m_in_strip = (m_in_strip + 1) % (mh / 8);
        end
      end
    end
    #1;
  endtask

  task automatic cyc();
    in_valid  = (vmode == 1) || (vmode == 2 && $urandom_range(0, 1) == 1);
    out_ready = (rmode == 1) || (rmode == 2 && $urandom_range(0, 2) != 0);
    px        = coord ? coord_px() : 24'($urandom);
    tick();
  endtask

  task automatic feed_acc(input int n, input int budget);
    int target = m_acc_total + n;
    while (m_acc_total < target && budget > 0) begin
      cyc();
      budget--;
    end
    check("feed_done", 32'(m_acc_total), 32'(target));
  endtask

  task automatic drain(input int budget);
    vmode = 0;
    while (expq.size() > 0 && budget > 0) begin
      cyc();
      budget--;
    end
    check("drain_done", 32'(expq.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0; px = '0;
    vmode = 0; rmode = 0; coord = 1'b0; mw = 16; mh = 16; m_acc_total = 0;
    model_reset();
    clear_stats();
    @(posedge clk); #1;
    do_reset();

    // Reset state (flags are checked unqualified here)
    cyc();
    check("rst_sof", 32'(o_sof), 32'd0);
    check("rst_eol", 32'(o_eol), 32'd0);
    check("rst_eof", 32'(o_eof), 32'd0);

    // Reorder: two blocks of coordinate-coded pixels
    clear_stats();
    coord = 1'b1; vmode = 1; rmode = 1;
    feed_acc(128, 500);
    drain(500);
    check("reorder_count", 32'(n_out), 32'd128);
    check("reorder_eol", 32'(n_eol), 32'd8);
    check("reorder_sof", 32'(n_sof), 32'd1);

    // Frame: two frames of 4 blocks back to back
    do_reset();
    clear_stats();
    vmode = 1; rmode = 1;
    feed_acc(256, 1000);
    drain(1000);
    check("frame_eof_count", 32'(n_eof), 32'd1);
    check("frame_eof_idx", 32'(eof_idx), 32'd255);
    vmode = 1;
    feed_acc(256, 1000);
    drain(1000);
    check("frame2_sof_count", 32'(n_sof), 32'd2);
    check("frame2_sof_idx", 32'(last_sof_idx), 32'd256);
    check("frame2_eof_count", 32'(n_eof), 32'd2);

    // Backpressure: 3 strips offered with the consumer stalled
    coord = 1'b0; vmode = 1; rmode = 0;
    for (int i = 0; i < 384; i++) cyc();
    check("bp_overflow", 32'(o_ovf), 32'd1);
    check("bp_accepted", 32'(m_cnt), 32'd2);
    rmode = 1;
    drain(1000);

    // Stall stability under random handshakes on both sides
    clear_stats();
    vmode = 2; rmode = 2;
    feed_acc(384, 4000);
    drain(4000);
    check("stall_count", 32'(n_out), 32'd384);

    // Reset mid-strip, then a clean strip
    coord = 1'b1; vmode = 1; rmode = 1;
    feed_acc(70, 200);
    do_reset();
    vmode = 0;
    cyc();
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_ready", 32'(o_in_ready), 32'd1);
    check("mid_rst_ovf", 32'(o_ovf), 32'd0);
    clear_stats();
    vmode = 1;
    feed_acc(128, 500);
    drain(500);
    check("post_rst_count", 32'(n_out), 32'd128);
    check("post_rst_sof", 32'(n_sof), 32'd1);

    // Default geometry: 300 blocks of 160x120
    vmode = 0; rmode = 0; coord = 1'b0;
    sel = 1'b1; mw = 160; mh = 120;
    do_reset();
    clear_stats();
    vmode = 1; rmode = 1;
    feed_acc(19200, 25000);
    drain(5000);
    check("full_count", 32'(n_out), 32'd19200);
    check("full_eol", 32'(n_eol), 32'd120);
    check("full_eof", 32'(n_eof), 32'd1);
    check("full_sof", 32'(n_sof), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
